// File: rtl/shot_controller_pkg.sv
// Shared constants, state typedef and starting fleet layouts for the shot controller.
// Layouts are built from 100-bit ship masks (bit 10r+c = row r, col c).
package shot_controller_pkg;

   localparam logic [1:0] CELL_WATER = 2'b00;
   localparam logic [1:0] CELL_SHIP  = 2'b01;
   localparam logic [1:0] CELL_MISS  = 2'b10;
   localparam logic [1:0] CELL_HIT   = 2'b11;

   localparam logic [7:0] KEY_BREAK   = 8'hF0;
   localparam logic [7:0] KEY_EXT     = 8'hE0;
   localparam logic [7:0] KEY_UP      = 8'h1D;
   localparam logic [7:0] KEY_DOWN    = 8'h1B;
   localparam logic [7:0] KEY_LEFT    = 8'h1C;
   localparam logic [7:0] KEY_RIGHT   = 8'h23;
   localparam logic [7:0] KEY_FIRE    = 8'h5A;
   localparam logic [7:0] KEY_RESTART = 8'h2D;

   typedef enum logic [2:0] {IDLE, SKIP, FIRE, UPDATE, DONE} state_e;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic fire;
      logic restart;
      logic brk;
   } key_cmd_t;

   function automatic logic [199:0] expand_layout(input logic [99:0] mask);
      logic [199:0] r;
      r = '0;
      for (int i = 0; i < 100; i++) r[2*i +: 2] = {1'b0, mask[i]};
      return r;
   endfunction

   // Rows listed row9 first; within a row col9 is the leftmost bit.
   localparam logic [199:0] P1_LAYOUT = expand_layout({
      10'b1100000000, 10'b0000000000, 10'b0001110000, 10'b0001000000, 10'b0001000111,
      10'b0001000000, 10'b0001000000, 10'b0000000000, 10'b0000000000, 10'b0000111110});

   localparam logic [199:0] P2_LAYOUT = expand_layout({
      10'b0000000000, 10'b0000000011, 10'b0000000000, 10'b1110000000, 10'b0000000000,
      10'b0000011100, 10'b0000000000, 10'b0000001111, 10'b0000000000, 10'b1111100000});

endpackage

// File: rtl/shot_controller_if.sv
// Keyboard input and game-status outputs of the shot controller.
interface shot_controller_if #(parameter int BOARD_SIZE = 10);
   logic [7:0]                           key_code;
   logic                                 key_valid;
   logic [2*BOARD_SIZE*BOARD_SIZE-1:0]   disp_board;
   logic [3:0]                           cursor_row;
   logic [3:0]                           cursor_col;
   logic                                 player_turn;
   logic                                 shot_hit;
   logic                                 shot_miss;
   logic                                 shot_rejected;
   logic [4:0]                           hits_p1;
   logic [4:0]                           hits_p2;
   logic                                 game_over;
   logic                                 winner;

   modport slave (
      input  key_code, key_valid,
      output disp_board, cursor_row, cursor_col, player_turn, shot_hit, shot_miss,
             shot_rejected, hits_p1, hits_p2, game_over, winner
   );

   modport master (
      output key_code, key_valid,
      input  disp_board, cursor_row, cursor_col, player_turn, shot_hit, shot_miss,
             shot_rejected, hits_p1, hits_p2, game_over, winner
   );
endinterface

// File: rtl/shot_controller_key_decoder.sv
// Turns a strobed PS/2 byte into one-cycle command strobes; E0 prefixes produce nothing
// and F0 is flagged so the controller can drop the following release byte.
module key_decoder
   import shot_controller_pkg::*;
(
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output key_cmd_t   cmd
);

   always_comb begin
      cmd = '0;
      if (key_valid) begin
         unique case (key_code)
            KEY_BREAK:   cmd.brk     = 1'b1;
            KEY_UP:      cmd.up      = 1'b1;
            KEY_DOWN:    cmd.down    = 1'b1;
            KEY_LEFT:    cmd.left    = 1'b1;
            KEY_RIGHT:   cmd.right   = 1'b1;
            KEY_FIRE:    cmd.fire    = 1'b1;
            KEY_RESTART: cmd.restart = 1'b1;
            default:     ;
         endcase
      end
   end

endmodule

// File: rtl/shot_controller.sv
// Two-player battleship shot controller: cursor movement, shot resolution against the
// opponent board, hit counting, win detection and a ships-hidden view of the target board.
module shot_controller
   import shot_controller_pkg::*;
#(
   parameter int BOARD_SIZE = 10,
   parameter int SHIP_CELLS = 17
) (
   input  logic               clock50,
   input  logic               reset_n,
   shot_controller_if.slave   bus
);

   localparam int NC = BOARD_SIZE * BOARD_SIZE;
   localparam int BW = 2 * NC;
   localparam int IW = $clog2(BW);
   localparam logic [3:0] EDGE_MAX = 4'(BOARD_SIZE - 1);

   key_cmd_t cmd;

   state_e                  state_q, state_d;
   logic [1:0][BW-1:0]      board_q, board_d;
   logic [3:0]              row_q, row_d, col_q, col_d;
   logic                    turn_q, turn_d;
   logic [1:0][4:0]         hits_q, hits_d;
   logic                    go_q, go_d, win_q, win_d;
   logic [1:0]              cell_q, cell_d;
   logic                    hit_q, hit_d, miss_q, miss_d, rej_q, rej_d;

   logic                    opp;
   logic [IW-1:0]           cell_base;
   logic [BW-1:0]           view, disp;

   key_decoder u_key_decoder (
      .key_valid (bus.key_valid),
      .key_code  (bus.key_code),
      .cmd       (cmd)
   );

   assign opp       = ~turn_q;
   assign cell_base = IW'(2 * (int'(row_q) * BOARD_SIZE + int'(col_q)));

   always_comb begin
      state_d = state_q;
      board_d = board_q;
      row_d   = row_q;
      col_d   = col_q;
      turn_d  = turn_q;
      hits_d  = hits_q;
      go_d    = go_q;
      win_d   = win_q;
      cell_d  = cell_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      rej_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd.brk)       state_d = SKIP;
            else if (cmd.fire) state_d = FIRE;
            else begin
               if (cmd.up    && row_q != 4'd0)     row_d = row_q - 4'd1;
               if (cmd.down  && row_q != EDGE_MAX) row_d = row_q + 4'd1;
               if (cmd.left  && col_q != 4'd0)     col_d = col_q - 4'd1;
               if (cmd.right && col_q != EDGE_MAX) col_d = col_q + 4'd1;
            end
         end
         SKIP: if (bus.key_valid) state_d = IDLE;
         FIRE: begin
            cell_d  = board_q[opp][cell_base +: 2];
            state_d = UPDATE;
         end
         UPDATE: begin
            state_d = IDLE;
            case (cell_q)
               CELL_WATER: begin
                  board_d[opp][cell_base +: 2] = CELL_MISS;
                  miss_d = 1'b1;
                  turn_d = ~turn_q;
               end
               CELL_SHIP: begin
                  board_d[opp][cell_base +: 2] = CELL_HIT;
                  hit_d = 1'b1;
                  if (hits_q[turn_q] < 5'(SHIP_CELLS)) hits_d[turn_q] = hits_q[turn_q] + 5'd1;
                  // The winning shot freezes the turn so winner and player_turn agree.
                  if (hits_q[turn_q] + 5'd1 >= 5'(SHIP_CELLS)) begin
                     state_d = DONE;
                     go_d    = 1'b1;
                     win_d   = turn_q;
                  end else begin
                     turn_d = ~turn_q;
                  end
               end
               default: rej_d = 1'b1;
            endcase
         end
         DONE: begin
            if (cmd.restart) begin
               state_d = IDLE;
               board_d = {BW'(P2_LAYOUT), BW'(P1_LAYOUT)};
               row_d   = '0;
               col_d   = '0;
               turn_d  = 1'b0;
               hits_d  = '0;
               go_d    = 1'b0;
               win_d   = 1'b0;
               cell_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         board_q <= {BW'(P2_LAYOUT), BW'(P1_LAYOUT)};
         row_q   <= '0;
         col_q   <= '0;
         turn_q  <= 1'b0;
         hits_q  <= '0;
         go_q    <= 1'b0;
         win_q   <= 1'b0;
         cell_q  <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         row_q   <= row_d;
         col_q   <= col_d;
         turn_q  <= turn_d;
         hits_q  <= hits_d;
         go_q    <= go_d;
         win_q   <= win_d;
         cell_q  <= cell_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         rej_q   <= rej_d;
      end
   end

   // Shooter sees the opponent board with intact ships shown as water.
   assign view = board_q[opp];
   always_comb begin
      disp = '0;
      for (int i = 0; i < NC; i++)
         disp[2*i +: 2] = view[2*i+1] ? view[2*i +: 2] : CELL_WATER;
   end

   assign bus.disp_board    = disp;
   assign bus.cursor_row    = row_q;
   assign bus.cursor_col    = col_q;
   assign bus.player_turn   = turn_q;
   assign bus.shot_hit      = hit_q;
   assign bus.shot_miss     = miss_q;
   assign bus.shot_rejected = rej_q;
   assign bus.hits_p1       = hits_q[0];
   assign bus.hits_p2       = hits_q[1];
   assign bus.game_over     = go_q;
   assign bus.winner        = win_q;

endmodule

// File: tb/tb_shot_controller.sv
// Directed scenarios for shot_controller; shot results are queued at issue time and
// matched by a monitor whenever a result pulse appears.
module tb_shot_controller;
   import shot_controller_pkg::*;

   localparam logic [2:0] K_HIT  = 3'b100;
   localparam logic [2:0] K_MISS = 3'b010;
   localparam logic [2:0] K_REJ  = 3'b001;

   logic clock50 = 1'b0;
   logic reset_n = 1'b0;
   always #10 clock50 = ~clock50;

   shot_controller_if #(.BOARD_SIZE(10)) bus ();
   shot_controller #(.BOARD_SIZE(10), .SHIP_CELLS(17)) dut (
      .clock50 (clock50),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [2:0] kind;
      logic       turn;
      logic [4:0] h1;
      logic [4:0] h2;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, failures = 0, cyc = 0, pulse_cnt = 0;
   int   exp_h1 = 0, exp_h2 = 0, cur_r = 0, cur_c = 0;
   logic exp_turn = 1'b0;

   always @(posedge clock50) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   always @(negedge clock50) begin
      logic [2:0] k;
      exp_t e;
      k = {bus.shot_hit, bus.shot_miss, bus.shot_rejected};
      if (k != 3'b000) begin
         pulse_cnt++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse got=%b want=none", k);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", 200'(k), 200'(e.kind));
            chk("turn_after", 200'(bus.player_turn), 200'(e.turn));
            chk("hits_p1", 200'(bus.hits_p1), 200'(e.h1));
            chk("hits_p2", 200'(bus.hits_p2), 200'(e.h2));
            chk("pulse_cycle", 200'(cyc), 200'(e.cyc));
         end
      end
   end

   task automatic send_key(input logic [7:0] code);
      @(negedge clock50);
      bus.key_code  = code;
      bus.key_valid = 1'b1;
      @(negedge clock50);
      bus.key_valid = 1'b0;
   endtask

   task automatic goto(input int r, input int c);
      while (cur_r < r) begin send_key(KEY_DOWN);  cur_r++; end
      while (cur_r > r) begin send_key(KEY_UP);    cur_r--; end
      while (cur_c < c) begin send_key(KEY_RIGHT); cur_c++; end
      while (cur_c > c) begin send_key(KEY_LEFT);  cur_c--; end
   endtask

   task automatic fire(input logic [2:0] kind);
      exp_t e;
      bit   win;
      @(negedge clock50);
      bus.key_code  = KEY_FIRE;
      bus.key_valid = 1'b1;
      win = 1'b0;
      if (kind == K_HIT) begin
         if (!exp_turn) begin exp_h1++; win = (exp_h1 == 17); end
         else           begin exp_h2++; win = (exp_h2 == 17); end
      end
      if (kind != K_REJ && !win) exp_turn = ~exp_turn;
      e.kind = kind;
      e.turn = exp_turn;
      e.h1   = 5'(exp_h1);
      e.h2   = 5'(exp_h2);
      e.cyc  = cyc + 3;
      sb.push_back(e);
      @(negedge clock50);
      bus.key_valid = 1'b0;
      repeat (3) @(negedge clock50);
      chk("result_seen", 200'(sb.size()), 200'd0);
      sb.delete();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_row"}, 200'(bus.cursor_row), 200'd0);
      chk({tag, "_col"}, 200'(bus.cursor_col), 200'd0);
      chk({tag, "_turn"}, 200'(bus.player_turn), 200'd0);
      chk({tag, "_hits"}, 200'({bus.hits_p1, bus.hits_p2}), 200'd0);
      chk({tag, "_over"}, 200'({bus.game_over, bus.winner}), 200'd0);
      chk({tag, "_pulses"}, 200'({bus.shot_hit, bus.shot_miss, bus.shot_rejected}), 200'd0);
      chk({tag, "_disp"}, bus.disp_board, 200'd0);
   endtask

   // P1 shots that sink the P2 fleet after the (0,9) hit; p2h marks where P2's
   // reply at the same cell lands on a P1 ship.
   int win_r[16]   = '{0, 0, 0, 0, 2, 2, 2, 2, 4, 4, 4, 6, 6, 6, 8, 8};
   int win_c[16]   = '{5, 6, 7, 8, 0, 1, 2, 3, 2, 3, 4, 7, 8, 9, 0, 1};
   bit win_p2h[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   initial begin
      int pc;
      bus.key_code  = 8'h00;
      bus.key_valid = 1'b0;
      reset_n       = 1'b0;
      repeat (3) @(negedge clock50);
      chk_reset_state("in_reset");
      reset_n = 1'b1;
      @(negedge clock50);
      chk_reset_state("after_reset");

      // Key filtering
      pc = pulse_cnt;
      send_key(KEY_BREAK);
      send_key(KEY_FIRE);
      send_key(KEY_EXT);
      repeat (5) @(negedge clock50);
      chk("break_drops_enter", 200'(pulse_cnt), 200'(pc));
      send_key(KEY_UP);
      send_key(KEY_LEFT);
      chk("sat_low_row", 200'(bus.cursor_row), 200'd0);
      chk("sat_low_col", 200'(bus.cursor_col), 200'd0);
      repeat (12) send_key(KEY_RIGHT);
      cur_c = 9;
      chk("sat_high_col", 200'(bus.cursor_col), 200'd9);
      goto(0, 0);
      chk("back_to_col0", 200'(bus.cursor_col), 200'd0);

      // Miss, P2 reply, rejected repeat
      fire(K_MISS);
      chk("disp_p1_hidden", bus.disp_board, 200'd0);
      fire(K_MISS);
      chk("disp_p2_miss00", bus.disp_board, 200'h2);
      fire(K_REJ);
      chk("turn_after_rej", 200'(bus.player_turn), 200'd0);

      // Hit at (0,9)
      goto(0, 9);
      fire(K_HIT);
      chk("hits_p1_one", 200'(bus.hits_p1), 200'd1);
      chk("disp_p1_after_hit", bus.disp_board, 200'h2);
      fire(K_MISS);
      chk("disp_p2_hit09", bus.disp_board, 200'hC0002);

      // Sink the rest of the P2 fleet
      for (int i = 0; i < 16; i++) begin
         goto(win_r[i], win_c[i]);
         fire(K_HIT);
         if (i < 15) fire(win_p2h[i] ? K_HIT : K_MISS);
      end
      chk("game_over", 200'(bus.game_over), 200'd1);
      chk("winner", 200'(bus.winner), 200'd0);
      chk("turn_frozen", 200'(bus.player_turn), 200'd0);
      chk("hits_p1_full", 200'(bus.hits_p1), 200'd17);
      chk("hits_p2_final", 200'(bus.hits_p2), 200'd1);

      pc = pulse_cnt;
      send_key(KEY_FIRE);
      send_key(KEY_RIGHT);
      repeat (5) @(negedge clock50);
      chk("done_ignores_enter", 200'(pulse_cnt), 200'(pc));
      chk("done_ignores_move", 200'(bus.cursor_col), 200'(cur_c));

      send_key(KEY_RESTART);
      chk_reset_state("restart");
      cur_r = 0; cur_c = 0; exp_turn = 1'b0; exp_h1 = 0; exp_h2 = 0;
      fire(K_MISS);
      chk("p1_board_reloaded", bus.disp_board, 200'd0);

      // Reset one cycle after Enter aborts the shot
      pc = pulse_cnt;
      @(negedge clock50);
      bus.key_code  = KEY_FIRE;
      bus.key_valid = 1'b1;
      @(negedge clock50);
      bus.key_valid = 1'b0;
      reset_n       = 1'b0;
      repeat (2) @(negedge clock50);
      reset_n = 1'b1;
      repeat (4) @(negedge clock50);
      chk("midshot_no_pulse", 200'(pulse_cnt), 200'(pc));
      chk_reset_state("midshot");
      exp_turn = 1'b0; exp_h1 = 0; exp_h2 = 0;
      fire(K_MISS);

      chk("scoreboard_empty", 200'(sb.size()), 200'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 SHALL have parameter BOARD_SIZE, default 10, board edge length in cells.
REQ-002 SHALL have parameter SHIP_CELLS, default 17, ship cells per player; reaching this hit count wins.
REQ-003 SHALL have port clock50  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_code  input  8  PS/2 scan code byte from the keyboard stage.
REQ-006 SHALL have port key_valid  input  1  one-cycle strobe; key_code is valid in that cycle.
REQ-007 SHALL have port disp_board  output  200  displayed 10x10 board: 2 bits per cell, row-major; row r at [20r+19:20r], column c at [2c+1:2c] within the row.
REQ-008 SHALL have port cursor_row, cursor_col  output  4 each  cursor position, 0..9.
REQ-009 SHALL have port player_turn  output  1  current shooter: 0 = player one, 1 = player two.
REQ-010 SHALL have port shot_hit, shot_miss, shot_rejected  output  1 each  one-cycle result pulses.
REQ-011 SHALL have port hits_p1, hits_p2  output  5 each  hits scored by each player.
REQ-012 SHALL have port game_over  output  1  level; high once a player has won.
REQ-013 SHALL have port winner  output  1  the winning player; valid while game_over is high.

Function
REQ-014 SHALL hold two boards of 2-bit cells, one per player. Cell codes: 00 water, 01 ship, 10 miss, 11 hit.
REQ-015 SHALL have FSM states IDLE, SKIP, FIRE, UPDATE, DONE.
REQ-016 IDLE, key 0xF0: SHALL go to SKIP. SKIP: the next valid byte is dropped, then SHALL return to IDLE.
REQ-017 IDLE, key 0xE0: SHALL be ignored, staying in IDLE.
REQ-018 IDLE, cursor keys, each moving one step and saturating at 0 and 9 (no wrap):
- W (0x1D): row-1
- S (0x1B): row+1
- A (0x1C): col-1
- D (0x23): col+1
REQ-019 IDLE, Enter (0x5A): SHALL go to FIRE at the next edge; other codes SHALL be ignored.
REQ-020 FIRE SHALL read the opponent board cell at the cursor and go to UPDATE.
REQ-021 UPDATE SHALL act on the cell value read, with all effects taking place at one edge:
- 00: write 10, pulse shot_miss, toggle player_turn.
- 01: write 11, pulse shot_hit, add 1 to the shooter's hit count, toggle player_turn.
- 10 or 11: no write, pulse shot_rejected, keep player_turn.
REQ-022 Latency SHALL be fixed: Enter strobed in cycle N gives its result pulse and turn change in cycle N+3.
REQ-023 A hit that brings the shooter's count to SHIP_CELLS SHALL:
- enter DONE
- set game_over = 1 and winner = shooter
- leave player_turn unchanged
REQ-024 DONE SHALL ignore every key except R (0x2D); R SHALL reload both layouts, clear counters and return to IDLE, identical to reset.
REQ-025 A key_valid arriving in FIRE or UPDATE SHALL be dropped; no queuing.
REQ-026 disp_board SHALL be purely combinational: the opponent board of player_turn, with code 01 shown as 00 (ships hidden).
REQ-027 Hit counters SHALL be 5-bit and SHALL NOT exceed SHIP_CELLS.

Reset
REQ-028 While reset_n is low, asynchronously:
- boards = package layouts
- state = IDLE, player_turn = 0
- cursor = (0,0), hits = 0
- game_over = 0, winner = 0
- all pulses = 0
REQ-029 Reset asserted mid-shot (FIRE/UPDATE) SHALL abort the shot with no board write.

Structure
REQ-030 A shared package SHALL hold:
- the cell-code constants
- the scan-code constants
- the FSM state typedef
- P1_LAYOUT and P2_LAYOUT (200-bit each)
REQ-031 P2_LAYOUT SHALL have a ship at (row 0, col 9) and water at (row 0, col 0); P1_LAYOUT SHALL have a ship at (row 0, col 3).
REQ-032 The block SHALL contain one sub-module, key_decoder: it handles F0/E0 filtering and produces one-cycle move/fire/restart strobes.

Verification
REQ-033 Scenario, miss: reset; Enter at (0,0) -> shot_miss in cycle N+3; P2 cell(0,0) = 10; player_turn = 1; disp_board now shows P1's board.
REQ-034 Scenario, hit: reset; D x9 then Enter -> shot_hit; P2 cell(0,9) = 11; hits_p1 = 1; disp_board shows cell(0,9) of P2 as 11 once it is player one's turn again.
REQ-035 Scenario, rejected shot: P1 misses (0,0); P2 misses anywhere; P1 fires (0,0) again -> shot_rejected; player_turn stays 0.
REQ-036 Scenario, key filtering: bytes F0,5A -> no shot. W at row 0 and A at col 0 -> cursor stays (0,0). D x12 -> col = 9.
REQ-037 Scenario, win and restart: script 17 P1 hits interleaved with P2 misses -> game_over = 1, winner = 0; further Enter -> no pulse; R -> all state equals the reset state.
REQ-038 Scenario, mid-shot reset: reset_n low in cycle N+1 after Enter -> no write, outputs at reset values.
